// File: rtl/wb_reg_master.sv
// wb_reg_master: valid/ready register command port to single Wishbone strobe transactions with timeout
//   clk, reset_n                          clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata   command port
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err           response port
//   stb_o/we_o/adr_wr_o/adr_rd_o/dat_o/dat_i/ack_i  split-address Wishbone initiator
module wb_reg_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] adr_wr_o,
    output logic [DATA_WIDTH-1:0] adr_rd_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    logic [1:0] state;
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            adr_wr_o  <= '0;
            adr_rd_o  <= '0;
            dat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        stb_o     <= 1'b1;
                        we_o      <= cmd_we;
                        adr_wr_o  <= cmd_addr;
                        adr_rd_o  <= cmd_addr;
                        dat_o     <= cmd_we ? cmd_wdata : '0;
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // ack is checked first so an ack on the final timeout cycle still counts as success
                    if (ack_i || cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        rsp_rdata <= (ack_i && !we_o) ? dat_i : '0;
                        rsp_err   <= !ack_i;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_reg_master.sv
// tb_wb_reg_master: directed self-checking bench for wb_reg_master with a register-slave model
module tb_wb_reg_master;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [7:0] rsp_rdata;
    logic       stb_o, we_o, ack_i;
    logic [7:0] adr_wr_o, adr_rd_o, dat_o, dat_i;
    logic       ack_en = 1'b1, ack_force = 1'b0;
    logic [7:0] wait_n = 8'd0, stb_cnt;
    logic [7:0] mem [256];
    int         vectors = 0, miscompares = 0;

    wb_reg_master #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .stb_o(stb_o), .we_o(we_o), .adr_wr_o(adr_wr_o), .adr_rd_o(adr_rd_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    assign ack_i = ack_force | (ack_en && stb_o && stb_cnt == wait_n);
    assign dat_i = mem[adr_rd_o];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) stb_cnt <= '0;
        else stb_cnt <= (stb_o && !ack_i) ? stb_cnt + 8'd1 : 8'd0;
    end

    always @(posedge clk) if (ack_i && stb_o && we_o) mem[adr_wr_o] <= dat_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input string tag, input logic we, input logic [7:0] a, input logic [7:0] d,
                           input int hold, input int exp_stb, input logic [7:0] exp_rd, input logic exp_err);
        int n = 0, n_stb = 0, unstable = 0;
        logic       c_we = 1'b0;
        logic [7:0] c_aw = '0, c_ar = '0, c_d = '0, r_d;
        logic       r_e;
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        rsp_ready = (hold == 0);
        tick();
        cmd_valid = 1'b0;
        while (!rsp_valid && n < 100) begin
            if (stb_o) begin
                if (n_stb == 0) begin
                    c_we = we_o; c_aw = adr_wr_o; c_ar = adr_rd_o; c_d = dat_o;
                end else if (we_o !== c_we || adr_wr_o !== c_aw || adr_rd_o !== c_ar || dat_o !== c_d) begin
                    unstable++;
                end
                n_stb++;
            end
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n + 1), 32'(exp_stb + 1));
        chk({tag, "_stb_cycles"}, 32'(n_stb), 32'(exp_stb));
        chk({tag, "_stb_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_we_o"}, 32'(c_we), 32'(we));
        chk({tag, "_adr_wr"}, 32'(c_aw), 32'(a));
        chk({tag, "_adr_rd"}, 32'(c_ar), 32'(a));
        chk({tag, "_dat_o"}, 32'(c_d), we ? 32'(d) : 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        r_d = rsp_rdata; r_e = rsp_err; unstable = 0;
        for (int i = 0; i < hold; i++) begin
            ack_force = 1'b1;
            tick();
            if (!rsp_valid || rsp_rdata !== r_d || rsp_err !== r_e || cmd_ready || stb_o) unstable++;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(unstable), 32'd0);
        ack_force = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_rsp_done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         idx, ridx, stall, rises, gap, min_gap, bad;
        logic       acc, rsp, sp, stall_now;
        logic [7:0] q_addr [4];
        logic [7:0] q_wdata [4];
        logic       q_we [4];
        logic [7:0] q_exp [4];
        q_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
        q_addr  = '{8'h30, 8'h30, 8'h31, 8'h31};
        q_wdata = '{8'hA1, 8'h00, 8'h7E, 8'h00};
        q_exp   = '{8'h00, 8'hA1, 8'h00, 8'h7E};
        mem[8'h22] = 8'hC3;
        mem[8'h40] = 8'h99;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", {28'd0, stb_o, we_o, rsp_valid, rsp_err}, 32'd0);
        chk("rst_buses", {adr_wr_o, adr_rd_o, dat_o, rsp_rdata}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("first_clk_ready", 32'(cmd_ready), 32'd1);

        run_cmd("wr_5a", 1'b1, 8'h10, 8'h5A, 0, 1, 8'h00, 1'b0);
        chk("slave_mem_10", 32'(mem[8'h10]), 32'h5A);
        run_cmd("rd_5a", 1'b0, 8'h10, 8'hFF, 0, 1, 8'h5A, 1'b0);
        wait_n = 8'd3;
        run_cmd("rd_wait3", 1'b0, 8'h22, 8'h00, 0, 4, 8'hC3, 1'b0);
        wait_n = 8'd15;
        run_cmd("rd_ack_last", 1'b0, 8'h40, 8'h00, 0, 16, 8'h99, 1'b0);
        ack_en = 1'b0;
        run_cmd("timeout", 1'b0, 8'h40, 8'h00, 3, 16, 8'h00, 1'b1);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("stray_ack_idle", {29'd0, stb_o, rsp_valid, cmd_ready}, 32'b001);
        ack_en = 1'b1; wait_n = 8'd0;

        idx = 0; ridx = 0; stall = 0; rises = 0; gap = 0; min_gap = 99; bad = 0;
        cmd_valid = 1'b1; cmd_we = q_we[0]; cmd_addr = q_addr[0]; cmd_wdata = q_wdata[0];
        for (int c = 0; c < 200 && ridx < 4; c++) begin
            stall_now = rsp_valid && ridx == 1 && stall < 5;
            rsp_ready = !stall_now;
            if (stall_now) begin
                stall++;
                if (rsp_rdata !== q_exp[1] || rsp_err || cmd_ready || stb_o) bad++;
            end
            acc = cmd_valid && cmd_ready;
            rsp = rsp_valid && rsp_ready;
            sp  = stb_o;
            if (rsp) begin
                chk($sformatf("queue_rdata_%0d", ridx), 32'(rsp_rdata), 32'(q_exp[ridx]));
                ridx++;
            end
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    cmd_we = q_we[idx]; cmd_addr = q_addr[idx]; cmd_wdata = q_wdata[idx];
                end else cmd_valid = 1'b0;
            end
            if (stb_o && !sp) begin
                rises++;
                if (rises > 1 && gap < min_gap) min_gap = gap;
            end
            gap = stb_o ? 0 : gap + 1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("queue_responses", 32'(ridx), 32'd4);
        chk("queue_accepts", 32'(idx), 32'd4);
        chk("queue_stb_txns", 32'(rises), 32'd4);
        chk("queue_min_gap_ok", 32'(min_gap >= 2), 32'd1);
        chk("queue_stall_cycles", 32'(stall), 32'd5);
        chk("queue_stall_stable", 32'(bad), 32'd0);
        tick();

        ack_en = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("bus_before_rst", 32'(stb_o), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_in_bus", {29'd0, stb_o, rsp_valid, rsp_err}, 32'd0);
        tick();
        chk("rst_in_bus_ready", 32'(cmd_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_bus_first_clk", 32'(cmd_ready), 32'd1);

        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h10;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && !rsp_valid; c++) tick();
        chk("resp_before_rst", {30'd0, rsp_valid, rsp_err}, 32'b11);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_in_resp", {29'd0, stb_o, rsp_valid, rsp_err}, 32'd0);
        tick();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        ack_en = 1'b1;
        tick();
        run_cmd("post_rst_wr", 1'b1, 8'h12, 8'h3C, 0, 1, 8'h00, 1'b0);
        chk("slave_mem_12", 32'(mem[8'h12]), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_reg_master.md
# wb_reg_master

Wishbone initiator that converts single register read/write commands from a valid/ready command port into one-cycle-or-longer strobe transactions on the split-address Wishbone bus used by the FASM register slaves. It sits between a local controller (CPU bridge, debug port or sequencer) and one or more Wishbone register slaves. It issues exactly one transaction at a time, captures read data on acknowledge, and reports a timeout error if no acknowledge arrives.

## Interface
Parameters:
- DATA_WIDTH, 8, width of address and data buses (matches register slaves)
- TIMEOUT_CYCLES, 16, maximum stb_o cycles without ack_i before abort; legal range 1..255

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  DATA_WIDTH  register address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  1 = transaction timed out
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_wr_o  out  DATA_WIDTH  write address
- adr_rd_o  out  DATA_WIDTH  read address
- dat_o  out  DATA_WIDTH  write data to slave
- dat_i  in  DATA_WIDTH  read data from slave
- ack_i  in  1  Wishbone acknowledge

## Operation
- All outputs registered. Reset values: cmd_ready 0 while reset_n low, then 1 from first clock in IDLE; everything else 0; state IDLE; timeout counter 0.
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready: latch we, addr, wdata; drive stb_o=1, we_o=cmd_we, adr_wr_o=adr_rd_o=cmd_addr, dat_o=cmd_wdata (dat_o=0 for reads); cmd_ready=0; counter=0; go BUS.
- BUS: stb_o, we_o, addresses, dat_o held stable.
  - ack_i=1: stb_o=0, we_o=0; rsp_rdata = dat_i if read, else 0; rsp_err=0; rsp_valid=1; go RESP.
  - ack_i=0 and counter = TIMEOUT_CYCLES-1: stb_o=0, we_o=0; rsp_rdata=0; rsp_err=1; rsp_valid=1; go RESP.
  - otherwise counter += 1 (8-bit, never wraps given legal range).
- RESP: rsp_valid, rsp_rdata, rsp_err held until rsp_ready=1; on that edge rsp_valid=0, rsp_err=0, cmd_ready=1, go IDLE.
- ack_i ignored outside BUS. Addresses/dat_o keep last value after transaction; only stb_o qualifies them.
- Reset asserted in any state: immediate return to reset values; any in-flight transaction is dropped with no response.

## Timing
- Zero-wait slave (ack_i = stb_o combinationally): command accepted at edge 0, stb_o high cycle 1, rsp_valid high from edge 2. Command-to-response latency 2 cycles; each wait state adds 1.
- Timeout: stb_o asserted exactly TIMEOUT_CYCLES cycles, rsp_valid rises on the edge ending the last one.
- stb_o is never high on two transactions back-to-back; minimum command spacing 3 cycles (accept, BUS, RESP with rsp_ready=1).
- ack_i on the final timeout cycle wins: response is success, rsp_err=0.
- rsp_rdata is sampled from dat_i on the ack edge only; later dat_i changes do not affect it.

## Test plan
- Write 0x5A to address 0x10, zero-wait slave, rsp_ready=1 -> stb_o=1, we_o=1, adr_wr_o=0x10, dat_o=0x5A for exactly 1 cycle; rsp_valid 1 cycle later with rsp_err=0, rsp_rdata=0x00.
- Read address 0x10 from a register slave holding 0x5A -> stb_o=1, we_o=0, adr_rd_o=0x10; rsp_rdata=0x5A, rsp_err=0, latency 2 cycles.
- Slave with 3 wait states (ack_i on 4th stb cycle), read returning 0xC3 -> stb_o high 4 cycles, rsp_rdata=0xC3, latency 5 cycles; ack on cycle TIMEOUT_CYCLES -> success, not error.
- ack_i tied 0, TIMEOUT_CYCLES=16 -> stb_o high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; stray ack_i pulse in RESP/IDLE ignored.
- cmd_valid held high with 4 queued commands, rsp_ready low 5 cycles on the 2nd response -> rsp_valid/rsp_rdata stable throughout, cmd_ready=0 until rsp_ready, all 4 commands executed in order, never two stb_o transactions without an idle gap.
- reset_n pulsed low during BUS and during RESP -> stb_o, rsp_valid, rsp_err drop asynchronously; after release, cmd_ready=1 on first clock and a fresh write completes normally.
